// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: IDLE -> ISSUE -> HOLD with jump/branch redirect.
// Optional fetch timeout compiled in with `define IFETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_err
);

`ifdef IFETCH_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic          r_valid;
    logic          r_err;
    logic [TW-1:0] r_tcnt;

    logic          w_load;
    logic          w_consume;
    logic          w_timeout;
    logic [31:0]   w_pc_plus4;
    logic [31:0]   w_pc_nxt;
    logic          w_unused;

    assign w_pc_plus4 = r_pc + 32'd4;

    // With the feature compiled out the constant enable removes the counter and error flag.
    assign w_timeout = TIMEOUT_EN && (r_state == S_ISSUE) && !imem_ready &&
                       (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            S_IDLE:  w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (imem_ready || w_timeout) begin
                    w_state_nxt = S_HOLD;
                    w_load      = 1'b1;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_state_nxt = S_ISSUE;
                    w_consume   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pc_nxt = w_pc_plus4;
        if (jump)
            w_pc_nxt = {w_pc_plus4[31:28], jump_index, 2'b00};
        else if (branch_taken)
            w_pc_nxt = {branch_target[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_instr <= imem_ready ? imem_rdata : '0;
                r_valid <= 1'b1;
            end
            if (w_consume) begin
                r_valid <= 1'b0;
                r_pc    <= w_pc_nxt;
            end
            if (w_timeout)
                r_err <= 1'b1;
            if ((r_state == S_ISSUE) && !imem_ready && !w_timeout)
                r_tcnt <= r_tcnt + 1'b1;
            else
                r_tcnt <= '0;
        end
    end

    assign imem_req    = (r_state == S_ISSUE);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign pc_plus4    = w_pc_plus4;
    assign instr_valid = r_valid;
    assign fetch_err   = r_err;

    // Branch targets are forced word-aligned, so the low bits are deliberately dropped.
    assign w_unused = ^branch_target[1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; timeout check follows `define IFETCH_TIMEOUT_EN.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_err;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .instr         (instr),
        .opcode        (opcode),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        imem_rdata    = 32'h2001_0001;
        imem_ready    = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_index    = '0;

        // Reset state
        step();
        step();
        chk("rst_req",   imem_req,    0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr,       0);
        chk("rst_err",   fetch_err,   0);
        chk("rst_addr",  imem_addr,   32'h0);

        // Streaming fetch with ready always high
        rst_n = 1'b1;
        chk("idle_req", imem_req, 0);
        step();
        chk("s1_req",   imem_req,    1);
        chk("s1_addr",  imem_addr,   32'h0);
        chk("s1_valid", instr_valid, 0);
        step();
        chk("s2_valid", instr_valid, 1);
        chk("s2_instr", instr,       32'h2001_0001);
        chk("s2_req",   imem_req,    0);
        chk("s2_pcp4",  pc_plus4,    32'h4);
        imem_rdata = 32'h2002_0002;
        step();
        chk("s3_valid", instr_valid, 0);
        chk("s3_req",   imem_req,    1);
        chk("s3_addr",  imem_addr,   32'h4);
        step();
        chk("s4_valid", instr_valid, 1);
        chk("s4_instr", instr,       32'h2002_0002);
        step();
        chk("s5_addr",  imem_addr,   32'h8);
        chk("s5_req",   imem_req,    1);

        // Hold under stall; redirects ignored while stalled
        rst_n = 1'b0;
        step();
        chk("rst2_addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        step();
        chk("h_issue_addr", imem_addr, 32'h0);
        imem_rdata    = 32'h8C22_0004;
        stall         = 1'b1;
        jump          = 1'b1;
        jump_index    = 26'h3FF_FFFF;
        branch_taken  = 1'b1;
        branch_target = 32'h1234_5678;
        step();
        chk("h_instr",  instr,       32'h8C22_0004);
        chk("h_opcode", opcode,      6'b100011);
        chk("h_valid",  instr_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("h_loop_req",   imem_req,    0);
            chk("h_loop_instr", instr,       32'h8C22_0004);
            chk("h_loop_valid", instr_valid, 1);
            chk("h_loop_op",    opcode,      6'b100011);
        end
        stall        = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        step();
        chk("h_next_addr",  imem_addr,   32'h4);
        chk("h_next_req",   imem_req,    1);
        chk("h_next_valid", instr_valid, 0);

        // Misaligned branch to 0x0040_0010, then jump beats branch
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0013;
        step();
        chk("br1_addr", imem_addr, 32'h0040_0010);
        branch_taken = 1'b0;
        step();
        chk("br1_pcp4", pc_plus4, 32'h0040_0014);
        jump          = 1'b1;
        jump_index    = 26'h100_0000;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        step();
        chk("jmp_addr", imem_addr, 32'h0400_0000);

        // Redirects have no effect while waiting in ISSUE
        imem_ready = 1'b0;
        step();
        chk("iss_hold_addr", imem_addr,   32'h0400_0000);
        chk("iss_hold_req",  imem_req,    1);
        chk("iss_hold_val",  instr_valid, 0);
        imem_ready    = 1'b1;
        jump          = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0123;
        step();
        chk("br2_hold_valid", instr_valid, 1);
        step();
        chk("br2_addr", imem_addr, 32'h0000_0120);

        // Sequential wrap at the top of the address space
        step();
        branch_target = 32'hFFFF_FFFC;
        step();
        chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        step();
        chk("wrap_pcp4", pc_plus4, 32'h0);
        step();
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset abandons a pending fetch
        step();
        step();
        chk("ab_pre_addr", imem_addr, 32'h4);
        imem_ready = 1'b0;
        step();
        chk("ab_wait_addr", imem_addr, 32'h4);
        rst_n = 1'b0;
        step();
        chk("ab_rst_valid", instr_valid, 0);
        chk("ab_rst_req",   imem_req,    0);
        chk("ab_rst_addr",  imem_addr,   32'h0);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        chk("ab_idle_req", imem_req, 0);
        step();
        chk("ab_issue_req",   imem_req,    1);
        chk("ab_issue_addr",  imem_addr,   32'h0);
        chk("ab_issue_valid", instr_valid, 0);

        // Memory never answers
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
`ifdef IFETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_wait_valid", instr_valid, 0);
            chk("to_wait_err",   fetch_err,   0);
        end
        step();
        chk("to_err",   fetch_err,   1);
        chk("to_instr", instr,       32'h0);
        chk("to_valid", instr_valid, 1);
        chk("to_req",   imem_req,    0);
        step();
        chk("to_next_addr", imem_addr, 32'h4);
        chk("to_sticky",    fetch_err, 1);
`else
        for (int i = 0; i < 40; i++) begin
            step();
            chk("nto_req",   imem_req,    1);
            chk("nto_valid", instr_valid, 0);
            chk("nto_err",   fetch_err,   0);
        end
        chk("nto_addr", imem_addr, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
